ttm_regbank: RTL and testbench
==============================

# ttm_regbank

Parametrised register bank for the TTM4 emulator core, the successor to the fixed 8-bit REGISTERS block. It holds the program counter, the nibble-addressed jump register, N output-port registers and a synchronised input port, all sized by generics. It adds PC auto-increment with a wrap flag, a muxed load bus with source and nibble select, and input-change detection. It sits between the instruction decoder, which drives the active-low strobes, and the ALU, which uses STOREBUS and LOADBUS.

## Interface
- NIB_W, 4, data-bus (nibble) width
- NIBS, 2, nibbles per register; PA/JR/IR/each OR are NIBS*NIB_W bits wide
- N_OR, 2, number of output-port registers
- IR_SYNC, 2, input synchroniser stages (≥2)
- SW = max(1,clog2(NIBS)); OW = max(1,clog2(N_OR)) (derived, not overridable)

- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-low
- nPC_INC  in  1  low: PC ← PC+1
- nPC_LD  in  1  low: PC ← JR; overrides nPC_INC
- nJR_ST  in  1  low: JR nibble ST_SEL ← STOREBUS
- nOR_ST  in  1  low: OR[OR_SEL] nibble ST_SEL ← STOREBUS
- ST_SEL  in  SW  store nibble index
- OR_SEL  in  OW  output register index
- LD_SRC  in  1  LOADBUS source: 0 = JR, 1 = synchronised IR
- LD_SEL  in  SW  LOADBUS nibble index
- nLD_OUT  in  1  low: drive selected nibble on LOADBUS; high: LOADBUS = 0
- STOREBUS  in  NIB_W  write data
- IR  in  NIBS*NIB_W  asynchronous external input port
- PA  out  NIBS*NIB_W  program counter / program address
- LOADBUS  out  NIB_W  read data
- OR  out  N_OR*NIBS*NIB_W  output ports, channel k at bits [k*NIBS*NIB_W +: NIBS*NIB_W]
- PC_WRAP  out  1  one-cycle pulse after PC wraps all-ones→0 by increment
- IR_CHG  out  1  one-cycle pulse when synchronised IR value changes

## Operation
- Reset (RST low, asynchronous): PC, JR, all OR channels, all IR sync stages, the IR history register and PC_WRAP are cleared to 0. Outputs while reset is held: PA=0, OR=0, LOADBUS=0, PC_WRAP=0, IR_CHG=0. Reset asserted mid-operation clears state immediately, with no clock needed.
- PC: priority is nPC_LD, then nPC_INC, then hold. Increment is modulo 2^(NIBS*NIB_W).
- PC_WRAP is registered. It is set on the edge where an increment moves PC from all-ones to 0 and cleared on the next edge. A load never sets it, even a load of 0.
- JR/OR stores are independent and may occur in the same cycle. Each writes only the addressed nibble; the other nibbles hold.
- An out-of-range ST_SEL (≥NIBS) or OR_SEL (≥N_OR) makes the write a no-op.
- Simultaneous nPC_LD and nJR_ST: PC takes the pre-write JR value.
- IR path: an IR_SYNC-stage flop chain; the last stage is ir_q. The history register ir_d1 ← ir_q every cycle. IR_CHG = (ir_q ≠ ir_d1), decoded from registers only.
- Because reset values are 0, a nonzero IR present at reset release produces one IR_CHG pulse.
- LOADBUS is combinational from registers: nLD_OUT high gives 0; otherwise it carries nibble LD_SEL of (LD_SRC ? ir_q : JR). An out-of-range LD_SEL gives 0.
- There is no path from IR, STOREBUS or the strobes to any output without passing through a flop, except the LOADBUS select/enable inputs.

## Timing
- Strobes are sampled on the rising CLK edge. State and PA are visible immediately after that edge (latency 1).
- A JR store followed by nPC_LD in the next cycle loads the new value.
- IR pin to LOADBUS: IR_SYNC edges. IR_CHG is high for exactly the cycle after ir_q updates.
- PC_WRAP is high for the cycle following the wrapping edge.
- Holding a strobe low for k cycles acts k times: PC increments k times, and stores rewrite the same value.

## Test plan
Bench defaults: NIB_W=4, NIBS=2, N_OR=2, IR_SYNC=2.
- Reset: drive RST low for 4 cycles → PA=0, OR=0x0000, LOADBUS=0. Increment to PA=0x03, then pull RST low between edges → PA=0 at once.
- Store: STOREBUS=0x5 with nJR_ST and nOR_ST low, ST_SEL=0, OR_SEL=0; then STOREBUS=0xA with ST_SEL=1 → JR=0xA5, OR=0x00A5. Pulse nPC_LD → PA=0xA5.
- Wrap: load JR=0xFE then increment 2 cycles → PA 0xFF, then 0x00; PC_WRAP=1 for the cycle after the second edge only. nPC_LD of JR=0x00 → PC_WRAP stays 0.
- Priority: nPC_LD and nPC_INC together with JR=0x12 → PA=0x12. nPC_LD and nJR_ST (ST_SEL=0, data 0x7) together → PA=0x12, JR=0x17.
- Input: set IR=0x7E with LD_SRC=1, LD_SEL=0, nLD_OUT=0 → LOADBUS=0xE after 2 edges and IR_CHG pulses once. LD_SEL=1 → 0x7. nLD_OUT=1 → 0. IR=0x00 → a second IR_CHG pulse.
- Channel select: OR_SEL=1, ST_SEL=1, data 0xC → OR=0xC0A5 with channel 0 unchanged. Out-of-range index with N_OR=3 (OR_SEL=3) → no register changes.

Source files
------------

// File: rtl/ttm_regbank.sv
// ttm_regbank -- parametrised register bank for the TTM4 emulator core.
//
// Holds the program counter (PA), the nibble-addressed jump register (JR),
// N_OR output-port registers (OR) and a synchronised copy of the external
// input port (IR). The decoder drives the active-low strobes; the ALU writes
// through STOREBUS and reads through LOADBUS.
//
// Ports:
//   CLK       rising-edge system clock
//   RST       asynchronous active-low reset
//   nPC_INC   low: PC <- PC + 1 (modulo 2^(NIBS*NIB_W))
//   nPC_LD    low: PC <- JR (wins over nPC_INC, uses pre-store JR)
//   nJR_ST    low: JR nibble ST_SEL <- STOREBUS
//   nOR_ST    low: OR[OR_SEL] nibble ST_SEL <- STOREBUS
//   ST_SEL    store nibble index (out of range: no write)
//   OR_SEL    output register index (out of range: no write)
//   LD_SRC    LOADBUS source, 0 = JR, 1 = synchronised IR
//   LD_SEL    LOADBUS nibble index (out of range: LOADBUS = 0)
//   nLD_OUT   low: drive selected nibble on LOADBUS, high: LOADBUS = 0
//   STOREBUS  write data nibble
//   IR        asynchronous external input port
//   PA        program counter
//   LOADBUS   read data nibble (combinational from registers)
//   OR        output ports, channel k at [k*NIBS*NIB_W +: NIBS*NIB_W]
//   PC_WRAP   one-cycle pulse after an increment wraps PC to 0
//   IR_CHG    one-cycle pulse when the synchronised IR value changes
module ttm_regbank #(
    parameter int NIB_W   = 4,
    parameter int NIBS    = 2,
    parameter int N_OR    = 2,
    parameter int IR_SYNC = 2
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic                                         nPC_INC,
    input  logic                                         nPC_LD,
    input  logic                                         nJR_ST,
    input  logic                                         nOR_ST,
    input  logic [((NIBS > 1) ? $clog2(NIBS) : 1)-1:0]   ST_SEL,
    input  logic [((N_OR > 1) ? $clog2(N_OR) : 1)-1:0]   OR_SEL,
    input  logic                                         LD_SRC,
    input  logic [((NIBS > 1) ? $clog2(NIBS) : 1)-1:0]   LD_SEL,
    input  logic                                         nLD_OUT,
    input  logic [NIB_W-1:0]                             STOREBUS,
    input  logic [NIBS*NIB_W-1:0]                        IR,
    output logic [NIBS*NIB_W-1:0]                        PA,
    output logic [NIB_W-1:0]                             LOADBUS,
    output logic [N_OR*NIBS*NIB_W-1:0]                   OR,
    output logic                                         PC_WRAP,
    output logic                                         IR_CHG
);

    localparam int RW = NIBS * NIB_W;
    localparam int SW = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int OW = (N_OR > 1) ? $clog2(N_OR) : 1;

    logic [RW-1:0] pc_q, pc_d;
    logic          wrap_q, wrap_d;
    logic [RW-1:0] jr_q, jr_d;
    logic [RW-1:0] or_q [N_OR];
    logic [RW-1:0] or_d [N_OR];
    logic [RW-1:0] ir_sync_q [IR_SYNC];
    logic [RW-1:0] ir_sync_d [IR_SYNC];
    logic [RW-1:0] ir_d1_q, ir_d1_d;
    logic [RW-1:0] ir_q;
    logic [RW-1:0] ld_src_word;

    assign ir_q = ir_sync_q[IR_SYNC-1];

    // Program counter: load beats increment; only an increment from
    // all-ones raises the wrap flag, so a load of 0 never does.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (!nPC_LD) begin
            pc_d = jr_q;
        end else if (!nPC_INC) begin
            pc_d   = pc_q + RW'(1);
            wrap_d = &pc_q;
        end
    end

    // Nibble stores. Matching the index against every legal nibble/channel
    // makes an out-of-range index fall through as a no-op.
    always_comb begin
        jr_d = jr_q;
        if (!nJR_ST) begin
            for (int n = 0; n < NIBS; n++) begin
                if (ST_SEL == SW'(n)) begin
                    jr_d[n*NIB_W +: NIB_W] = STOREBUS;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_OR; k++) begin
            or_d[k] = or_q[k];
        end
        if (!nOR_ST) begin
            for (int k = 0; k < N_OR; k++) begin
                for (int n = 0; n < NIBS; n++) begin
                    if (OR_SEL == OW'(k) && ST_SEL == SW'(n)) begin
                        or_d[k][n*NIB_W +: NIB_W] = STOREBUS;
                    end
                end
            end
        end
    end

    // Input synchroniser chain plus a one-deep history for change detection.
    always_comb begin
        ir_sync_d[0] = IR;
        for (int s = 1; s < IR_SYNC; s++) begin
            ir_sync_d[s] = ir_sync_q[s-1];
        end
        ir_d1_d = ir_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q    <= '0;
            wrap_q  <= 1'b0;
            jr_q    <= '0;
            ir_d1_q <= '0;
            for (int k = 0; k < N_OR; k++) begin
                or_q[k] <= '0;
            end
            for (int s = 0; s < IR_SYNC; s++) begin
                ir_sync_q[s] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            jr_q    <= jr_d;
            ir_d1_q <= ir_d1_d;
            for (int k = 0; k < N_OR; k++) begin
                or_q[k] <= or_d[k];
            end
            for (int s = 0; s < IR_SYNC; s++) begin
                ir_sync_q[s] <= ir_sync_d[s];
            end
        end
    end

    // Read path: only the select/enable inputs reach LOADBUS without a flop.
    always_comb begin
        ld_src_word = LD_SRC ? ir_q : jr_q;
        LOADBUS     = '0;
        if (!nLD_OUT) begin
            for (int n = 0; n < NIBS; n++) begin
                if (LD_SEL == SW'(n)) begin
                    LOADBUS = ld_src_word[n*NIB_W +: NIB_W];
                end
            end
        end
    end

    always_comb begin
        OR = '0;
        for (int k = 0; k < N_OR; k++) begin
            OR[k*RW +: RW] = or_q[k];
        end
    end

    assign PA      = pc_q;
    assign PC_WRAP = wrap_q;
    assign IR_CHG  = (ir_q != ir_d1_q);

endmodule

// File: tb/tb_ttm_regbank.sv
// Directed testbench for ttm_regbank (NIB_W=4, NIBS=2, N_OR=2, IR_SYNC=2),
// with a second N_OR=3 instance to reach an out-of-range OR_SEL.
module tb_ttm_regbank;

    logic        clk;
    logic        rst_n;
    logic        n_pc_inc, n_pc_ld, n_jr_st, n_or_st, n_or_st3;
    logic [0:0]  st_sel;
    logic [0:0]  or_sel;
    logic [1:0]  or_sel3;
    logic        ld_src;
    logic [0:0]  ld_sel;
    logic        n_ld_out;
    logic [3:0]  storebus;
    logic [7:0]  ir;
    logic [7:0]  pa, pa3;
    logic [3:0]  loadbus, loadbus3;
    logic [15:0] or_o;
    logic [23:0] or3;
    logic        pc_wrap, pc_wrap3, ir_chg, ir_chg3;

    int total = 0;
    int bad   = 0;

    ttm_regbank #(.NIB_W(4), .NIBS(2), .N_OR(2), .IR_SYNC(2)) u_dut (
        .CLK(clk), .RST(rst_n), .nPC_INC(n_pc_inc), .nPC_LD(n_pc_ld),
        .nJR_ST(n_jr_st), .nOR_ST(n_or_st), .ST_SEL(st_sel), .OR_SEL(or_sel),
        .LD_SRC(ld_src), .LD_SEL(ld_sel), .nLD_OUT(n_ld_out),
        .STOREBUS(storebus), .IR(ir), .PA(pa), .LOADBUS(loadbus), .OR(or_o),
        .PC_WRAP(pc_wrap), .IR_CHG(ir_chg)
    );

    ttm_regbank #(.NIB_W(4), .NIBS(2), .N_OR(3), .IR_SYNC(2)) u_dut3 (
        .CLK(clk), .RST(rst_n), .nPC_INC(n_pc_inc), .nPC_LD(n_pc_ld),
        .nJR_ST(n_jr_st), .nOR_ST(n_or_st3), .ST_SEL(st_sel), .OR_SEL(or_sel3),
        .LD_SRC(ld_src), .LD_SEL(ld_sel), .nLD_OUT(n_ld_out),
        .STOREBUS(storebus), .IR(ir), .PA(pa3), .LOADBUS(loadbus3), .OR(or3),
        .PC_WRAP(pc_wrap3), .IR_CHG(ir_chg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; n_pc_inc = 1'b1; n_pc_ld = 1'b1; n_jr_st = 1'b1;
        n_or_st = 1'b1; n_or_st3 = 1'b1; st_sel = '0; or_sel = '0; or_sel3 = '0;
        ld_src = 1'b0; ld_sel = '0; n_ld_out = 1'b0; storebus = '0; ir = '0;

        // Reset held for 4 cycles
        repeat (4) step();
        chk("rst_pa", 32'(pa), 32'h00);
        chk("rst_or", 32'(or_o), 32'h0000);
        chk("rst_loadbus", 32'(loadbus), 32'h0);
        chk("rst_wrap", 32'(pc_wrap), 32'h0);
        chk("rst_irchg", 32'(ir_chg), 32'h0);

        // Increment to 3, then asynchronous reset between edges
        rst_n = 1'b1;
        n_pc_inc = 1'b0;
        repeat (3) step();
        chk("inc3_pa", 32'(pa), 32'h03);
        n_pc_inc = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("async_rst_pa", 32'(pa), 32'h00);
        step();
        rst_n = 1'b1;

        // Nibble stores into JR and OR channel 0
        n_jr_st = 1'b0; n_or_st = 1'b0; n_or_st3 = 1'b0;
        st_sel = 1'b0; or_sel = 1'b0; or_sel3 = 2'd0; storebus = 4'h5;
        step();
        chk("st0_or", 32'(or_o), 32'h0005);
        chk("st0_jr_lo", 32'(loadbus), 32'h5);
        st_sel = 1'b1; storebus = 4'hA;
        step();
        n_jr_st = 1'b1; n_or_st = 1'b1; n_or_st3 = 1'b1;
        chk("st1_or", 32'(or_o), 32'h00A5);
        ld_sel = 1'b1;
        #1;
        chk("st1_jr_hi", 32'(loadbus), 32'hA);
        n_pc_ld = 1'b0;
        step();
        n_pc_ld = 1'b1;
        chk("ld_pa", 32'(pa), 32'hA5);

        // Wrap: JR=0xFE, load, increment twice
        n_jr_st = 1'b0; st_sel = 1'b0; storebus = 4'hE;
        step();
        st_sel = 1'b1; storebus = 4'hF;
        step();
        n_jr_st = 1'b1;
        n_pc_ld = 1'b0;
        step();
        n_pc_ld = 1'b1;
        chk("wrap_ld_pa", 32'(pa), 32'hFE);
        n_pc_inc = 1'b0;
        step();
        chk("wrap_ff_pa", 32'(pa), 32'hFF);
        chk("wrap_ff_flag", 32'(pc_wrap), 32'h0);
        step();
        n_pc_inc = 1'b1;
        chk("wrap_00_pa", 32'(pa), 32'h00);
        chk("wrap_00_flag", 32'(pc_wrap), 32'h1);
        step();
        chk("wrap_hold_pa", 32'(pa), 32'h00);
        chk("wrap_clr_flag", 32'(pc_wrap), 32'h0);
        n_jr_st = 1'b0; st_sel = 1'b0; storebus = 4'h0;
        step();
        st_sel = 1'b1;
        step();
        n_jr_st = 1'b1;
        n_pc_ld = 1'b0;
        step();
        n_pc_ld = 1'b1;
        chk("ld0_pa", 32'(pa), 32'h00);
        chk("ld0_flag", 32'(pc_wrap), 32'h0);

        // Priority: load beats increment; load sees pre-store JR
        n_jr_st = 1'b0; st_sel = 1'b0; storebus = 4'h2;
        step();
        st_sel = 1'b1; storebus = 4'h1;
        step();
        n_jr_st = 1'b1;
        n_pc_ld = 1'b0; n_pc_inc = 1'b0;
        step();
        n_pc_inc = 1'b1;
        chk("prio_inc_pa", 32'(pa), 32'h12);
        n_jr_st = 1'b0; st_sel = 1'b0; storebus = 4'h7;
        step();
        n_pc_ld = 1'b1; n_jr_st = 1'b1;
        chk("prio_st_pa", 32'(pa), 32'h12);
        ld_sel = 1'b0;
        #1;
        chk("prio_jr_lo", 32'(loadbus), 32'h7);
        ld_sel = 1'b1;
        #1;
        chk("prio_jr_hi", 32'(loadbus), 32'h1);
        chk("prio_or_hold", 32'(or_o), 32'h00A5);

        // Input synchroniser, LOADBUS from IR, change detect
        ir = 8'h7E; ld_src = 1'b1; ld_sel = 1'b0; n_ld_out = 1'b0;
        step();
        chk("ir_e1_loadbus", 32'(loadbus), 32'h0);
        chk("ir_e1_chg", 32'(ir_chg), 32'h0);
        step();
        chk("ir_e2_loadbus", 32'(loadbus), 32'hE);
        chk("ir_e2_chg", 32'(ir_chg), 32'h1);
        step();
        chk("ir_e3_chg", 32'(ir_chg), 32'h0);
        ld_sel = 1'b1;
        #1;
        chk("ir_hi_loadbus", 32'(loadbus), 32'h7);
        n_ld_out = 1'b1;
        #1;
        chk("ir_off_loadbus", 32'(loadbus), 32'h0);
        ir = 8'h00;
        step();
        chk("ir0_e1_chg", 32'(ir_chg), 32'h0);
        step();
        chk("ir0_e2_chg", 32'(ir_chg), 32'h1);
        step();
        chk("ir0_e3_chg", 32'(ir_chg), 32'h0);

        // Channel select and out-of-range channel
        n_ld_out = 1'b0; ld_src = 1'b0;
        n_or_st = 1'b0; n_or_st3 = 1'b0;
        or_sel = 1'b1; or_sel3 = 2'd1; st_sel = 1'b1; storebus = 4'hC;
        step();
        n_or_st = 1'b1; n_or_st3 = 1'b1;
        chk("ch1_or", 32'(or_o), 32'hC0A5);
        chk("ch1_or3", 32'(or3), 32'h00C0A5);
        n_or_st3 = 1'b0; or_sel3 = 2'd3; st_sel = 1'b0; storebus = 4'h3;
        step();
        chk("oor_or3", 32'(or3), 32'h00C0A5);
        chk("oor_or", 32'(or_o), 32'hC0A5);
        or_sel3 = 2'd2;
        step();
        n_or_st3 = 1'b1;
        chk("ch2_or3", 32'(or3), 32'h03C0A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
